// File: rtl/arm_pkg.sv
// Shared types and constants for the Armstrong-number generator: FSM states,
// decimal place values and the digit power table (d^1, d^2, d^3 for d = 0..9).
package arm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHund,
        StTens,
        StSum,
        StEmit,
        StFin
    } arm_state_e;

    localparam int unsigned Hundred = 100;
    localparam int unsigned Ten     = 10;

    // Three entries per digit, ordered by power 1, 2, 3.
    localparam logic [9:0] PowTab [30] = '{
        10'd0, 10'd0,  10'd0,
        10'd1, 10'd1,  10'd1,
        10'd2, 10'd4,  10'd8,
        10'd3, 10'd9,  10'd27,
        10'd4, 10'd16, 10'd64,
        10'd5, 10'd25, 10'd125,
        10'd6, 10'd36, 10'd216,
        10'd7, 10'd49, 10'd343,
        10'd8, 10'd64, 10'd512,
        10'd9, 10'd81, 10'd729
    };

    function automatic logic [9:0] digit_pow(input logic [3:0] digit, input logic [1:0] power);
        logic [9:0] res;
        res = '0;
        if (digit <= 4'd9 && power != 2'd0) begin
            res = PowTab[int'(digit) * 3 + int'(power) - 1];
        end
        return res;
    endfunction

endpackage

// File: rtl/arm_digit_pow.sv
// Combinational digit^power lookup (digit 0..9, power 1..3) from the package table.
module arm_digit_pow
    import arm_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic [1:0] power_i,
    output logic [9:0] pow_o
);

    assign pow_o = digit_pow(digit_i, power_i);

endmodule

// File: rtl/arm_gen.sv
// Armstrong-number scanner: walks candidates 0..MAX_NUM, emits matches on a valid/ready port.
// Optional feature macro ARM_GEN_COUNT_EN builds the transfer counter; otherwise count is 0.
module arm_gen
    import arm_pkg::*;
#(
    parameter int unsigned MAX_NUM = 999,
    parameter int unsigned W       = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] num,
    output logic         num_valid,
    input  logic         num_ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] HundW = W'(Hundred);
    localparam logic [W-1:0] TenW  = W'(Ten);
    localparam logic [W-1:0] MaxW  = W'(MAX_NUM);

    arm_state_e   state_q;
    logic [W-1:0] cand_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] num_q;
    logic [3:0]   hund_q;
    logic [3:0]   tens_q;
    logic         num_valid_q;
    logic         busy_q;
    logic         done_q;

    logic [1:0]   ndig;
    logic [9:0]   pow_h;
    logic [9:0]   pow_t;
    logic [9:0]   pow_u;
    logic [11:0]  pow_sum;
    logic         match;
    logic         last;

    always_comb begin
        ndig = 2'd1;
        if (cand_q >= HundW) begin
            ndig = 2'd3;
        end else if (cand_q >= TenW) begin
            ndig = 2'd2;
        end
    end

    // In SUM the remainder has been reduced below ten, so it is the units digit.
    arm_digit_pow u_pow_h (.digit_i(hund_q),     .power_i(ndig), .pow_o(pow_h));
    arm_digit_pow u_pow_t (.digit_i(tens_q),     .power_i(ndig), .pow_o(pow_t));
    arm_digit_pow u_pow_u (.digit_i(rem_q[3:0]), .power_i(ndig), .pow_o(pow_u));

    assign pow_sum = 12'(pow_h) + 12'(pow_t) + 12'(pow_u);
    assign match   = (32'(pow_sum) == 32'(cand_q));
    assign last    = (cand_q == MaxW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cand_q      <= '0;
            rem_q       <= '0;
            num_q       <= '0;
            hund_q      <= '0;
            tens_q      <= '0;
            num_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cand_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    rem_q   <= cand_q;
                    hund_q  <= '0;
                    tens_q  <= '0;
                    state_q <= StHund;
                end
                StHund: begin
                    if (rem_q >= HundW) begin
                        rem_q  <= rem_q - HundW;
                        hund_q <= hund_q + 4'd1;
                    end else begin
                        state_q <= StTens;
                    end
                end
                StTens: begin
                    if (rem_q >= TenW) begin
                        rem_q  <= rem_q - TenW;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        state_q <= StSum;
                    end
                end
                StSum: begin
                    if (match) begin
                        num_q       <= cand_q;
                        num_valid_q <= 1'b1;
                        state_q     <= StEmit;
                    end else if (last) begin
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        cand_q  <= cand_q + 1'b1;
                        state_q <= StLoad;
                    end
                end
                StEmit: begin
                    if (num_ready) begin
                        num_valid_q <= 1'b0;
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            cand_q  <= cand_q + 1'b1;
                            state_q <= StLoad;
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef ARM_GEN_COUNT_EN
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == StIdle && start) begin
            count_q <= '0;
        end else if (state_q == StEmit && num_ready) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
`else
    assign count = '0;
`endif

    assign num       = num_q;
    assign num_valid = num_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/arm_gen.md
ARM_GEN -- requirements
Module: arm_gen

Interface
REQ-001 Parameter MAX_NUM, default 999, meaning the last candidate scanned (inclusive); legal range 0..999.
REQ-002 Parameter W, default 10, meaning the width of the number and count buses.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins a scan; ignored unless the block is idle.
REQ-006 num  output  W  the current Armstrong number; valid only while num_valid=1.
REQ-007 num_valid  output  1  num holds a found Armstrong number.
REQ-008 num_ready  input  1  the consumer accepts num this cycle.
REQ-009 busy  output  1  a scan is in progress.
REQ-010 done  output  1  one-cycle pulse after the last candidate is finished.
REQ-011 count  output  W  number of Armstrong numbers emitted in the current or last scan.

Function
REQ-012 Armstrong rule: a candidate with d digits (d=1..3; 0 counts as 1 digit) SHALL be emitted iff the sum of each digit raised to the power d equals the candidate.
REQ-013 For MAX_NUM=999, the emitted sequence SHALL be exactly 0,1,...,9,153,370,371,407 in ascending order.
REQ-014 States SHALL be IDLE, LOAD, HUND, TENS, SUM, EMIT and FIN.
REQ-015 IDLE to LOAD on start; LOAD latches the candidate into a working remainder and clears the digit registers.
REQ-016 HUND: while remainder>=100, subtract 100 and increment the hundreds digit, one subtraction per cycle; otherwise go to TENS.
REQ-017 TENS: the same as HUND with 10; the remaining value is the units digit; then go to SUM.
REQ-018 SUM: compute the power sum and compare it in one cycle; on a match go to EMIT, otherwise go to the next candidate.
REQ-019 Per-candidate latency SHALL be at most 22 cycles from LOAD to the SUM decision.
REQ-020 EMIT: num_valid=1 and num SHALL be held stable until the cycle in which num_valid and num_ready are both high; that cycle is the transfer.
REQ-021 num_ready=1 on the first EMIT cycle SHALL complete the transfer in that cycle; back-pressure of any length SHALL be tolerated without loss or duplication.
REQ-022 count SHALL increment by 1 on each transfer, never on a non-match.
REQ-023 Next candidate: if the candidate equals MAX_NUM, go to FIN; otherwise increment the candidate and go to LOAD; the candidate SHALL never wrap.
REQ-024 FIN SHALL assert done for exactly one cycle, then return to IDLE; count holds until the next start.
REQ-025 start while busy=1 SHALL be ignored, including during EMIT.
REQ-026 A start in the FIN cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-027 A new start SHALL clear count to 0 and restart the scan at candidate 0.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 rst=1 SHALL force IDLE and set num=0, num_valid=0, busy=0, done=0, count=0 and candidate=0 on the next edge.
REQ-030 rst SHALL take priority over start, num_ready and all in-flight operations, including a pending EMIT, which is dropped.

Configuration
REQ-031 Macro ARM_GEN_COUNT_EN: when defined, count behaves as in REQ-022/027; when undefined, the counter is not built and count is tied to 0.
REQ-032 No other behaviour SHALL differ between the two builds.

Structure
REQ-033 Package arm_pkg SHALL hold the state enumeration, the constants 100 and 10, and the digit power table (digit^1, ^2, ^3 for digits 0..9).
REQ-034 Combinational sub-module arm_digit_pow (inputs: digit, power; output: digit^power, 10 bits) SHALL be instantiated three times inside SUM.

Verification
REQ-035 rst, then one start pulse with num_ready held at 1 -> transfers 0..9,153,370,371,407; done pulses once; count=14.
REQ-036 num_ready=0 for 5 cycles while num=153 is offered -> num held at 153 with num_valid=1 throughout; single transfer on release; next value 370.
REQ-037 start pulsed mid-scan (after num=5 is transferred) -> ignored; the sequence continues with 6; final count=14.
REQ-038 rst asserted while num=370 is pending -> num_valid=0, busy=0, count=0 on the next edge; a new start re-emits from 0.
REQ-039 MAX_NUM=200 -> emits 0..9,153; done pulses; count=11; no values above 200.
REQ-040 Build without ARM_GEN_COUNT_EN -> same num sequence as REQ-035; count is 0 throughout.
